// File: rtl/pll_rst_seq.sv
// PLL supervisor and channel reset sequencer on the free-running clkin1 domain.
// Optional macro PLL_RST_SEQ_LOSS_CNT_EN adds a saturating lock-loss counter output.
module pll_rst_seq #(
  parameter int NUM_CH              = 2,
  parameter int RST_HOLD_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int CH_GAP_CYCLES       = 8,
  parameter int MAX_RETRY           = 3
) (
  input  logic              clkin1,
  input  logic              rst,
  input  logic              pll_lock,
  input  logic              force_relock,
  output logic              pll_rst,
  output logic [NUM_CH-1:0] ch_rst,
  output logic              all_ready,
  output logic              fail,
  output logic [2:0]        state,
  output logic [3:0]        retry_cnt
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  ,
  output logic [15:0]       loss_cnt
`endif
);

  localparam int MAX_A = (RST_HOLD_CYCLES > LOCK_STABLE_CYCLES) ? RST_HOLD_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_B = (LOCK_TIMEOUT_CYCLES > CH_GAP_CYCLES) ? LOCK_TIMEOUT_CYCLES : CH_GAP_CYCLES;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAX_P + 1);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CH_GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CH - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [3:0]          retry_q, retry_d;
  logic                lock_meta_q, lock_s_q;
  logic                pll_rst_q, pll_rst_d;
  logic [NUM_CH-1:0]   ch_rst_q, ch_rst_d;
  logic                all_ready_q, all_ready_d;
  logic                fail_q, fail_d;

  // Two-flop synchroniser; only lock_s_q is ever consumed downstream.
  always_ff @(posedge clkin1 or posedge rst) begin
    if (rst) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
    end
  end

  always_ff @(posedge clkin1 or posedge rst) begin
    if (rst) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= '0;
      idx_q       <= '0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      ch_rst_q    <= '1;
      all_ready_q <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      retry_q     <= retry_d;
      pll_rst_q   <= pll_rst_d;
      ch_rst_q    <= ch_rst_d;
      all_ready_q <= all_ready_d;
      fail_q      <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    if (force_relock) begin
      state_d = S_RESET_PLL;
      cnt_d   = '0;
      idx_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        S_RESET_PLL: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s_q) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TO_LAST) begin
            retry_d = retry_q + 4'd1;
            cnt_d   = '0;
            state_d = (retry_q + 4'd1 == RETRY_MAX) ? S_FAIL : S_RESET_PLL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_STABLE: begin
          if (!lock_s_q) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STB_LAST) begin
            // With a single channel, releasing bit 0 already completes the sequence.
            state_d = (NUM_CH == 1) ? S_RUN : S_RELEASE;
            cnt_d   = '0;
            idx_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RELEASE: begin
          if (!lock_s_q) begin
            state_d = S_RESET_PLL;
            cnt_d   = '0;
            idx_d   = '0;
            retry_d = '0;
          end else if (cnt_q == GAP_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 1'b1;
            if (idx_q + 1'b1 == LAST_IDX) state_d = S_RUN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          if (!lock_s_q) begin
            state_d = S_RESET_PLL;
            cnt_d   = '0;
            idx_d   = '0;
            retry_d = '0;
          end
        end
        S_FAIL: ;
        default: begin
          state_d = S_RESET_PLL;
          cnt_d   = '0;
          idx_d   = '0;
          retry_d = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they register together with it.
  always_comb begin
    pll_rst_d   = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
    all_ready_d = (state_d == S_RUN);
    fail_d      = (state_d == S_FAIL);
    ch_rst_d    = '1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (state_d == S_RUN)          ch_rst_d[i] = 1'b0;
      else if (state_d == S_RELEASE) ch_rst_d[i] = (i > int'(idx_d));
    end
  end

  assign pll_rst   = pll_rst_q;
  assign ch_rst    = ch_rst_q;
  assign all_ready = all_ready_q;
  assign fail      = fail_q;
  assign state     = state_q;
  assign retry_cnt = retry_q;

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  logic [15:0] loss_q;
  logic        loss_evt;

  assign loss_evt = ((state_q == S_RELEASE) || (state_q == S_RUN)) && !lock_s_q;

  // Survives force_relock on purpose; only rst clears the history.
  always_ff @(posedge clkin1 or posedge rst) begin
    if (rst)                            loss_q <= '0;
    else if (loss_evt && loss_q != '1)  loss_q <= loss_q + 16'd1;
  end

  assign loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq: directed release/retry/recovery tables plus randomized lock
// activity checked against a phase/elapsed-time reference model.
module tb_pll_rst_seq;

  localparam int NCH  = 3;
  localparam int HOLD = 4;
  localparam int STB  = 8;
  localparam int TO   = 32;
  localparam int GAP  = 3;
  localparam int MAXR = 2;

  logic           clkin1;
  logic           rst;
  logic           pll_lock;
  logic           force_relock;
  logic           pll_rst;
  logic [NCH-1:0] ch_rst;
  logic           all_ready;
  logic           fail;
  logic [2:0]     state;
  logic [3:0]     retry_cnt;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  logic [15:0]    loss_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  pll_rst_seq #(
    .NUM_CH(NCH), .RST_HOLD_CYCLES(HOLD), .LOCK_STABLE_CYCLES(STB),
    .LOCK_TIMEOUT_CYCLES(TO), .CH_GAP_CYCLES(GAP), .MAX_RETRY(MAXR)
  ) dut (
    .clkin1(clkin1), .rst(rst), .pll_lock(pll_lock), .force_relock(force_relock),
    .pll_rst(pll_rst), .ch_rst(ch_rst), .all_ready(all_ready), .fail(fail),
    .state(state), .retry_cnt(retry_cnt)
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    , .loss_cnt(loss_cnt)
`endif
  );

  // clock / reset
  initial clkin1 = 1'b0;
  always #5 clkin1 = ~clkin1;

  // reference model: phase 0..5 with elapsed cycles in the phase
  int   m_ph, m_el, m_retry, m_loss;
  logic m_lk1, m_lk2;

  task automatic model_reset();
    m_ph = 0; m_el = 0; m_retry = 0; m_loss = 0;
    m_lk1 = 1'b0; m_lk2 = 1'b0;
  endtask

  task automatic model_step(input logic lk, input logic frc);
    logic ls;
    ls = m_lk2;
    m_lk2 = m_lk1;
    m_lk1 = lk;
    if ((m_ph == 3 || m_ph == 4) && !ls && m_loss < 65535) m_loss++;
    if (frc) begin
      m_ph = 0; m_el = 0; m_retry = 0;
    end else begin
      case (m_ph)
        0: begin
          m_el++;
          if (m_el == HOLD) begin m_ph = 1; m_el = 0; end
        end
        1: begin
          if (ls) begin m_ph = 2; m_el = 0; end
          else begin
            m_el++;
            if (m_el == TO) begin
              m_retry++;
              m_el = 0;
              m_ph = (m_retry == MAXR) ? 5 : 0;
            end
          end
        end
        2: begin
          if (!ls) begin m_ph = 1; m_el = 0; end
          else begin
            m_el++;
            if (m_el == STB) begin m_ph = (NCH == 1) ? 4 : 3; m_el = 0; m_retry = 0; end
          end
        end
        3: begin
          if (!ls) begin m_ph = 0; m_el = 0; m_retry = 0; end
          else begin
            m_el++;
            if (1 + m_el / GAP >= NCH) begin m_ph = 4; m_el = 0; end
          end
        end
        4: begin
          if (!ls) begin m_ph = 0; m_el = 0; m_retry = 0; end
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [NCH-1:0] exp_ch();
    logic [NCH-1:0] ones;
    ones = '1;
    if (m_ph == 3) return ones << (1 + m_el / GAP);
    if (m_ph == 4) return '0;
    return ones;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("m_pll_rst", 32'(pll_rst), 32'(m_ph == 0 || m_ph == 5));
    chk("m_ch_rst", 32'(ch_rst), 32'(exp_ch()));
    chk("m_all_ready", 32'(all_ready), 32'(m_ph == 4));
    chk("m_fail", 32'(fail), 32'(m_ph == 5));
    chk("m_state", 32'(state), 32'(m_ph));
    chk("m_retry", 32'(retry_cnt), 32'(m_retry));
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    chk("m_loss", 32'(loss_cnt), 32'(m_loss));
`endif
  endtask

  // driver tasks
  task automatic tick(input logic lk, input logic frc);
    pll_lock = lk;
    force_relock = frc;
    @(posedge clkin1);
    model_step(lk, frc);
    @(negedge clkin1);
    check_model();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    pll_lock = 1'b0;
    force_relock = 1'b0;
    repeat (2) @(posedge clkin1);
    @(negedge clkin1);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    int         k;
    logic       prst;
    logic [2:0] ch;
    logic       rdy;
    logic [2:0] st;
  } vec_t;

  localparam int NV = 11;
  vec_t tbl[NV];

  task automatic run_table(input string tag);
    int j;
    j = 0;
    for (int k = 0; k <= 25; k++) begin
      if (k > 0) tick(1'b1, 1'b0);
      if (j < NV && tbl[j].k == k) begin
        chk({tag, "_pll_rst"}, 32'(pll_rst), 32'(tbl[j].prst));
        chk({tag, "_ch_rst"}, 32'(ch_rst), 32'(tbl[j].ch));
        chk({tag, "_ready"}, 32'(all_ready), 32'(tbl[j].rdy));
        chk({tag, "_state"}, 32'(state), 32'(tbl[j].st));
        j++;
      end
    end
  endtask

  initial begin
    int hold;
    logic lk;

    tbl[0]  = '{0,  1'b1, 3'b111, 1'b0, 3'd0};
    tbl[1]  = '{3,  1'b1, 3'b111, 1'b0, 3'd0};
    tbl[2]  = '{4,  1'b0, 3'b111, 1'b0, 3'd1};
    tbl[3]  = '{5,  1'b0, 3'b111, 1'b0, 3'd2};
    tbl[4]  = '{12, 1'b0, 3'b111, 1'b0, 3'd2};
    tbl[5]  = '{13, 1'b0, 3'b110, 1'b0, 3'd3};
    tbl[6]  = '{15, 1'b0, 3'b110, 1'b0, 3'd3};
    tbl[7]  = '{16, 1'b0, 3'b100, 1'b0, 3'd3};
    tbl[8]  = '{18, 1'b0, 3'b100, 1'b0, 3'd3};
    tbl[9]  = '{19, 1'b0, 3'b000, 1'b1, 3'd4};
    tbl[10] = '{25, 1'b0, 3'b000, 1'b1, 3'd4};

    rst = 1'b1;
    pll_lock = 1'b0;
    force_relock = 1'b0;
    model_reset();

    // 1: release sequence
    apply_reset();
    chk("rst_fail", 32'(fail), 32'd0);
    chk("rst_retry", 32'(retry_cnt), 32'd0);
    run_table("rel");

    // 2: one-cycle lock glitch five cycles into STABLE
    apply_reset();
    for (int k = 1; k <= 22; k++) begin
      tick((k == 11) ? 1'b0 : 1'b1, 1'b0);
      case (k)
        13: chk("glitch_back_wait", 32'(state), 32'd1);
        21: begin
          chk("glitch_ch_held", 32'(ch_rst), 32'h7);
          chk("glitch_state_stable", 32'(state), 32'd2);
        end
        22: begin
          chk("glitch_release_state", 32'(state), 32'd3);
          chk("glitch_release_ch", 32'(ch_rst), 32'h6);
        end
        default: ;
      endcase
    end

    // 3: lock never arrives -> two timeouts -> FAIL
    apply_reset();
    for (int k = 1; k <= 100; k++) begin
      tick(1'b0, 1'b0);
      case (k)
        35: chk("to1_wait", 32'(state), 32'd1);
        36: begin
          chk("to1_state", 32'(state), 32'd0);
          chk("to1_pll_rst", 32'(pll_rst), 32'd1);
          chk("to1_retry", 32'(retry_cnt), 32'd1);
        end
        39: chk("to1_pll_rst_hold", 32'(pll_rst), 32'd1);
        40: chk("to2_pll_rst_low", 32'(pll_rst), 32'd0);
        71: chk("to2_wait", 32'(state), 32'd1);
        72, 100: begin
          chk("fail_flag", 32'(fail), 32'd1);
          chk("fail_retry", 32'(retry_cnt), 32'd2);
          chk("fail_state", 32'(state), 32'd5);
          chk("fail_pll_rst", 32'(pll_rst), 32'd1);
          chk("fail_ch_rst", 32'(ch_rst), 32'h7);
        end
        default: ;
      endcase
    end

    // 4: force_relock out of FAIL, then a full release
    tick(1'b0, 1'b1);
    chk("relock_state", 32'(state), 32'd0);
    chk("relock_fail", 32'(fail), 32'd0);
    chk("relock_retry", 32'(retry_cnt), 32'd0);
    run_table("rec");

    // 5: lock loss in RUN
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("loss_still_run", 32'(state), 32'd4);
    tick(1'b1, 1'b0);
    chk("loss_ch_rst", 32'(ch_rst), 32'h7);
    chk("loss_pll_rst", 32'(pll_rst), 32'd1);
    chk("loss_ready", 32'(all_ready), 32'd0);
    chk("loss_state", 32'(state), 32'd0);
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    chk("loss_cnt", 32'(loss_cnt), 32'd1);
`endif

    // 6: asynchronous reset between two releases
    apply_reset();
    for (int k = 1; k <= 14; k++) tick(1'b1, 1'b0);
    chk("mid_release_ch", 32'(ch_rst), 32'h6);
    #2 rst = 1'b1;
    #1;
    chk("arst_pll_rst", 32'(pll_rst), 32'd1);
    chk("arst_ch_rst", 32'(ch_rst), 32'h7);
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_ready", 32'(all_ready), 32'd0);
    model_reset();
    @(negedge clkin1);
    rst = 1'b0;

    // randomized lock activity with occasional force_relock
    hold = 0;
    lk = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (hold == 0) begin
        lk = ($urandom_range(0, 3) != 0);
        hold = $urandom_range(1, 40);
      end
      hold--;
      tick(lk, ($urandom_range(0, 63) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
